bmw_host_driver: RTL and testbench
==================================

// Module: bmw_host_driver
// PURPOSE
//  Host-side initiator for the 16-bit init/load/fetch/ack hash-core interface. Accepts message
//  words on a valid/ready stream, issues one init per message, loads each word with a full
//  request/ack handshake, then fetches the 16-word (256-bit) digest and presents it on an
//  output stream. Sits between the system datapath and the BMW core wrapper.
// PARAMETERS
//  W            16    data word width (core idata/odata width)
//  BLK_WORDS    32    words per 512-bit block
//  DIG_WORDS    16    digest words fetched per message
//  ACK_TIMEOUT  1024  max cycles a request may wait for ack before error
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  start       in   1   pulse: begin new message (ignored unless busy=0)
//  busy        out  1   high from accepted start until done/err
//  done        out  1   1-cycle pulse after last digest word accepted
//  err         out  1   sticky: protocol/timeout error; cleared by rst or next start
//  s_valid     in   1   message word valid
//  s_ready     out  1   message word accepted when s_valid&s_ready
//  s_data      in   W   message word, passed to core unchanged (core owns byte order)
//  s_last      in   1   last word of message; legal only at block word index BLK_WORDS-1
//  m_valid     out  1   digest word valid
//  m_ready     in   1   digest consumer ready
//  m_data      out  W   digest word; first word = most-significant 16 bits of digest
//  m_last      out  1   high with 16th digest word
//  core_init   out  1   1-cycle init pulse
//  core_load   out  1   load request, held until core_ack
//  core_fetch  out  1   fetch request, held until core_ack
//  core_idata  out  W   word being loaded, stable while core_load=1
//  core_ack    in   1   core acknowledge (shared for load and fetch)
//  core_odata  in   W   digest word, valid in the cycle core_ack=1 during fetch
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. All core_* and m_* outputs are registered.
//  States: IDLE, INIT, LD_IDLE, LD_REQ, FT_IDLE, FT_REQ, FT_OUT, ERR.
//  IDLE: start -> err<=0, busy<=1, INIT. INIT: core_init=1 exactly one cycle -> LD_IDLE.
//  LD_IDLE: s_ready = ~core_ack. On s_valid&s_ready: core_idata<=s_data, core_load<=1,
//   latch s_last, -> LD_REQ. s_last with word index != BLK_WORDS-1 -> ERR (word not loaded).
//  LD_REQ: on core_ack=1: core_load<=0, word index +1 (wraps 31->0, block count +1);
//   -> FT_IDLE if latched last, else LD_IDLE. No new request while core_ack still high.
//  FT_IDLE: if ~core_ack & ~m_valid: core_fetch<=1 -> FT_REQ.
//  FT_REQ: on core_ack=1: m_data<=core_odata, m_valid<=1, core_fetch<=0,
//   m_last<=(dig idx==DIG_WORDS-1), dig idx +1 -> FT_OUT.
//  FT_OUT: on m_valid&m_ready: m_valid<=0; if m_last -> done pulse, busy<=0, IDLE; else FT_IDLE.
//  Timeout: counter clears on entry to LD_REQ/FT_REQ, +1 per cycle without ack; reaching
//   ACK_TIMEOUT -> ERR. core_ack in the terminal-count cycle wins (no error).
//  ERR: core_load/core_fetch/m_valid forced 0, s_ready=0, err=1, busy=0; start -> INIT.
//  start while busy=1: ignored. Multi-block messages: one init only, blocks back to back.
//  Latency: load request asserted 1 cycle after stream accept; m_valid 1 cycle after ack.
//  Reset mid-operation: immediate return to reset values; partial message discarded.
// STRUCTURE
//  Shared pkg: state encoding, W, BLK_WORDS, DIG_WORDS, clog2-derived counter widths.
//  One sub-module natural: bmw_ack_watchdog (timeout counter, clear/enable/expire).
// TESTING (bench uses behavioural core responder: ack 1 cycle after request, held until
//  request drops; word 31 ack delayed 40 cycles; digest word i = 16'hD000+i)
//  1 block, s_data=16'h0000..16'h001F, s_last on 31 -> 1 init, 32 loads, 16 fetches,
//    m_data 16'hD000..16'hD00F, m_last on 16'hD00F, done pulse, err=0.
//  2 blocks (64 words) -> exactly 1 core_init, 64 load handshakes, digest as above.
//  m_ready low 10 cycles on 3rd digest word -> m_data holds 16'hD002, no core_fetch meanwhile.
//  s_last on word 5 -> err=1, core_load stays 0, no fetch; next start clears err, init pulses.
//  ACK_TIMEOUT=8, responder never acks -> err 8 cycles after core_load rise, core_load drops.
//  rst asserted during LD_REQ -> all outputs 0 next edge; fresh start completes normally.

Source files
------------

// File: rtl/bmw_host_driver_pkg.sv
// rtl/bmw_host_driver_pkg.sv - shared sizes, state encoding and width helper for the BMW host driver
package bmw_host_driver_pkg;

    localparam int BMW_W           = 16;
    localparam int BMW_BLK_WORDS   = 32;
    localparam int BMW_DIG_WORDS   = 16;
    localparam int BMW_ACK_TIMEOUT = 1024;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_INIT    = 3'd1;
    localparam state_t S_LD_IDLE = 3'd2;
    localparam state_t S_LD_REQ  = 3'd3;
    localparam state_t S_FT_IDLE = 3'd4;
    localparam state_t S_FT_REQ  = 3'd5;
    localparam state_t S_FT_OUT  = 3'd6;
    localparam state_t S_ERR     = 3'd7;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bmw_host_driver_if.sv
// rtl/bmw_host_driver_if.sv - control, message/digest streams and core handshake bundle
interface bmw_host_driver_if #(
    parameter int W = 16
) ();

    logic         start;
    logic         busy;
    logic         done;
    logic         err;

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;

    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;

    logic         core_init;
    logic         core_load;
    logic         core_fetch;
    logic [W-1:0] core_idata;
    logic         core_ack;
    logic [W-1:0] core_odata;

    modport master (
        input  start, s_valid, s_data, s_last, m_ready, core_ack, core_odata,
        output busy, done, err, s_ready, m_valid, m_data, m_last,
               core_init, core_load, core_fetch, core_idata
    );

    modport slave (
        output start, s_valid, s_data, s_last, m_ready, core_ack, core_odata,
        input  busy, done, err, s_ready, m_valid, m_data, m_last,
               core_init, core_load, core_fetch, core_idata
    );

endinterface

// File: rtl/bmw_ack_watchdog.sv
// rtl/bmw_ack_watchdog.sv - cycles-without-ack counter for an outstanding core request
module bmw_ack_watchdog
    import bmw_host_driver_pkg::*;
#(
    parameter int TIMEOUT = BMW_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_ack,
    output logic o_expire
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !i_ack && r_cnt != TC) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // An ack arriving in the terminal-count cycle suppresses expiry.
    assign o_expire = i_en & ~i_ack & (r_cnt == TC);

endmodule

// File: rtl/bmw_host_driver.sv
// rtl/bmw_host_driver.sv - init/load/fetch initiator feeding message words to a BMW core and streaming its digest
module bmw_host_driver
    import bmw_host_driver_pkg::*;
#(
    parameter int W           = BMW_W,
    parameter int BLK_WORDS   = BMW_BLK_WORDS,
    parameter int DIG_WORDS   = BMW_DIG_WORDS,
    parameter int ACK_TIMEOUT = BMW_ACK_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    bmw_host_driver_if.master   bus
);

    localparam int WI_W = cnt_width(BLK_WORDS);
    localparam int DI_W = cnt_width(DIG_WORDS);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(BLK_WORDS - 1);
    localparam logic [DI_W-1:0] DI_LAST = DI_W'(DIG_WORDS - 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_init;
    logic            r_load;
    logic            r_fetch;
    logic [W-1:0]    r_idata;
    logic            r_mvalid;
    logic [W-1:0]    r_mdata;
    logic            r_mlast;
    logic            r_last_in;
    logic [WI_W-1:0] r_wi;
    logic [DI_W-1:0] r_di;

    logic            w_s_ready;
    logic            w_s_fire;
    logic            w_wd_en;
    logic            w_expire;

    assign w_s_ready = (r_state == S_LD_IDLE) & ~bus.core_ack;
    assign w_s_fire  = w_s_ready & bus.s_valid;
    assign w_wd_en   = (r_state == S_LD_REQ) | (r_state == S_FT_REQ);

    bmw_ack_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (~w_wd_en),
        .i_en     (w_wd_en),
        .i_ack    (bus.core_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_init    <= 1'b0;
            r_load    <= 1'b0;
            r_fetch   <= 1'b0;
            r_idata   <= '0;
            r_mvalid  <= 1'b0;
            r_mdata   <= '0;
            r_mlast   <= 1'b0;
            r_last_in <= 1'b0;
            r_wi      <= '0;
            r_di      <= '0;
        end else begin
            r_init <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_init  <= 1'b1;
                        r_wi    <= '0;
                        r_di    <= '0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: r_state <= S_LD_IDLE;
                S_LD_IDLE: begin
                    if (w_s_fire) begin
                        // A message may only end on the final word of a block.
                        if (bus.s_last && r_wi != WI_LAST) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else begin
                            r_idata   <= bus.s_data;
                            r_load    <= 1'b1;
                            r_last_in <= bus.s_last;
                            r_state   <= S_LD_REQ;
                        end
                    end
                end
                S_LD_REQ: begin
                    if (bus.core_ack) begin
                        r_load  <= 1'b0;
                        r_wi    <= (r_wi == WI_LAST) ? '0 : r_wi + WI_W'(1);
                        r_state <= r_last_in ? S_FT_IDLE : S_LD_IDLE;
                    end else if (w_expire) begin
                        r_load  <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_FT_IDLE: begin
                    if (!bus.core_ack && !r_mvalid) begin
                        r_fetch <= 1'b1;
                        r_state <= S_FT_REQ;
                    end
                end
                S_FT_REQ: begin
                    if (bus.core_ack) begin
                        r_mdata  <= bus.core_odata;
                        r_mvalid <= 1'b1;
                        r_fetch  <= 1'b0;
                        r_mlast  <= (r_di == DI_LAST);
                        r_di     <= r_di + DI_W'(1);
                        r_state  <= S_FT_OUT;
                    end else if (w_expire) begin
                        r_fetch <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end
                end
                S_FT_OUT: begin
                    if (r_mvalid && bus.m_ready) begin
                        r_mvalid <= 1'b0;
                        if (r_mlast) begin
                            r_mlast <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_FT_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.s_ready    = w_s_ready;
    assign bus.m_valid    = r_mvalid;
    assign bus.m_data     = r_mdata;
    assign bus.m_last     = r_mlast;
    assign bus.core_init  = r_init;
    assign bus.core_load  = r_load;
    assign bus.core_fetch = r_fetch;
    assign bus.core_idata = r_idata;

endmodule

// File: tb/tb_bmw_host_driver.sv
// tb/tb_bmw_host_driver.sv - directed bench for bmw_host_driver with a behavioural core responder
module tb_bmw_host_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmw_host_driver_if #(.W(16)) b1 ();
    bmw_host_driver_if #(.W(16)) b2 ();

    bmw_host_driver #(.W(16), .BLK_WORDS(32), .DIG_WORDS(16), .ACK_TIMEOUT(1024)) dut1 (
        .clk (clk), .rst (rst), .bus (b1.master)
    );

    bmw_host_driver #(.W(16), .BLK_WORDS(32), .DIG_WORDS(16), .ACK_TIMEOUT(8)) dut2 (
        .clk (clk), .rst (rst), .bus (b2.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: ack one cycle after request (word 31 of a block: 40 cycles), held until request drops.
    int ld_idx, ft_idx, dly;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b1.core_ack <= 1'b0;
            dly         <= 0;
            ld_idx      <= 0;
            ft_idx      <= 0;
        end else begin
            if (b1.core_init) begin
                ld_idx <= 0;
                ft_idx <= 0;
            end
            if (b1.core_load || b1.core_fetch) begin
                if (b1.core_ack) begin
                    if (b1.core_load)  ld_idx <= (ld_idx + 1) % 32;
                    if (b1.core_fetch) ft_idx <= ft_idx + 1;
                end else if (dly >= ((b1.core_load && ld_idx == 31) ? 40 : 0)) begin
                    b1.core_ack <= 1'b1;
                end else begin
                    dly <= dly + 1;
                end
            end else begin
                b1.core_ack <= 1'b0;
                dly         <= 0;
            end
        end
    end
    assign b1.core_odata = 16'hD000 + 16'(ft_idx);

    assign b2.core_ack   = 1'b0;
    assign b2.core_odata = 16'h0000;

    int init_n = 0, load_n = 0, fetch_n = 0, rx_n = 0;
    logic [15:0] rx_d [0:255];
    logic        rx_l [0:255];
    always @(posedge clk) begin
        if (!rst) begin
            if (b1.core_init)                  init_n  <= init_n + 1;
            if (b1.core_load && b1.core_ack)   load_n  <= load_n + 1;
            if (b1.core_fetch && b1.core_ack)  fetch_n <= fetch_n + 1;
            if (b1.m_valid && b1.m_ready && rx_n < 256) begin
                rx_d[rx_n] <= b1.m_data;
                rx_l[rx_n] <= b1.m_last;
                rx_n       <= rx_n + 1;
            end
        end
    end

    task automatic do_start();
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
    endtask

    task automatic feed(input int n, input int last_idx, input int base);
        int t;
        for (int i = 0; i < n; i++) begin
            b1.s_valid = 1'b1;
            b1.s_data  = 16'(base + i);
            b1.s_last  = (i == last_idx);
            t = 0;
            while (!b1.s_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk_eq("feed_timeout", 32'(i), 32'hFFFF_FFFF);
            @(negedge clk);
        end
        b1.s_valid = 1'b0;
        b1.s_last  = 1'b0;
    endtask

    task automatic wait_done(input bit stall);
        int t, bad;
        bit stalled;
        t = 0;
        stalled = 1'b0;
        while (!b1.done && t < 3000) begin
            if (stall && !stalled && b1.m_valid && b1.m_data == 16'hD002) begin
                b1.m_ready = 1'b0;
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (b1.m_data !== 16'hD002 || !b1.m_valid) bad++;
                    if (b1.core_fetch) bad++;
                end
                b1.m_ready = 1'b1;
                stalled = 1'b1;
                chk_eq("stall_hold", 32'(bad), 32'd0);
            end
            @(negedge clk);
            t++;
        end
        chk_eq("done_seen", 32'(b1.done), 32'd1);
        if (stall) chk_eq("stall_seen", 32'(stalled), 32'd1);
        @(negedge clk);
        chk_eq("done_pulse", 32'(b1.done), 32'd0);
        chk_eq("busy_after", 32'(b1.busy), 32'd0);
    endtask

    task automatic check_digest(input int base);
        int nl;
        nl = 0;
        chk_eq("rx_count", 32'(rx_n - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk_eq("digest", 32'(rx_d[base + i]), 32'(16'hD000 + i));
            if (rx_l[base + i]) nl++;
        end
        chk_eq("m_last_cnt", 32'(nl), 32'd1);
        chk_eq("m_last_pos", 32'(rx_l[base + 15]), 32'd1);
    endtask

    task automatic run_msg(input string tag, input int nwords, input bit stall);
        int i0, l0, f0, r0;
        i0 = init_n; l0 = load_n; f0 = fetch_n; r0 = rx_n;
        do_start();
        chk_eq({tag, "_busy"}, 32'(b1.busy), 32'd1);
        feed(nwords, nwords - 1, 0);
        wait_done(stall);
        chk_eq({tag, "_inits"}, 32'(init_n - i0), 32'd1);
        chk_eq({tag, "_loads"}, 32'(load_n - l0), 32'(nwords));
        chk_eq({tag, "_fetches"}, 32'(fetch_n - f0), 32'd16);
        chk_eq({tag, "_err"}, 32'(b1.err), 32'd0);
        check_digest(r0);
    endtask

    initial begin
        int l0, f0, bad, cnt;
        b1.start = 0; b1.s_valid = 0; b1.s_data = 0; b1.s_last = 0; b1.m_ready = 1;
        b2.start = 0; b2.s_valid = 0; b2.s_data = 0; b2.s_last = 0; b2.m_ready = 1;
        repeat (3) @(negedge clk);
        chk_eq("reset_ctl", {b1.busy, b1.done, b1.err, b1.s_ready, b1.m_valid, b1.m_last}, 32'd0);
        chk_eq("reset_core", {b1.core_init, b1.core_load, b1.core_fetch}, 32'd0);
        chk_eq("reset_data", {b1.m_data, b1.core_idata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_msg("blk1", 32, 1'b0);
        run_msg("blk2", 64, 1'b0);
        run_msg("stall", 32, 1'b1);

        // s_last on word 5: error, no load of that word, no fetch
        l0 = load_n; f0 = fetch_n;
        do_start();
        feed(6, 5, 0);
        chk_eq("slast_err", 32'(b1.err), 32'd1);
        chk_eq("slast_busy", 32'(b1.busy), 32'd0);
        bad = 0;
        repeat (6) begin
            if (b1.core_load || b1.core_fetch || b1.s_ready) bad++;
            @(negedge clk);
        end
        chk_eq("slast_quiet", 32'(bad), 32'd0);
        chk_eq("slast_loads", 32'(load_n - l0), 32'd5);
        chk_eq("slast_fetches", 32'(fetch_n - f0), 32'd0);
        do_start();
        chk_eq("restart_err", 32'(b1.err), 32'd0);
        chk_eq("restart_init", 32'(b1.core_init), 32'd1);
        chk_eq("restart_busy", 32'(b1.busy), 32'd1);
        @(negedge clk);
        chk_eq("init_one_cycle", 32'(b1.core_init), 32'd0);
        l0 = rx_n;
        feed(32, 31, 0);
        wait_done(1'b0);
        check_digest(l0);

        // ACK_TIMEOUT=8 instance, core never acks
        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        @(negedge clk);
        b2.s_valid = 1'b1;
        b2.s_data  = 16'h1234;
        chk_eq("to_ready", 32'(b2.s_ready), 32'd1);
        @(negedge clk);
        b2.s_valid = 1'b0;
        chk_eq("to_load", 32'(b2.core_load), 32'd1);
        chk_eq("to_idata", 32'(b2.core_idata), 32'h1234);
        cnt = 0;
        while (!b2.err && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk_eq("to_cycles", 32'(cnt), 32'd8);
        chk_eq("to_load_drop", 32'(b2.core_load), 32'd0);
        chk_eq("to_busy", 32'(b2.busy), 32'd0);

        // reset while a load request is outstanding
        do_start();
        feed(1, -1, 16'h00A5);
        chk_eq("rst_pre_load", 32'(b1.core_load), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_ctl", {b1.busy, b1.done, b1.err, b1.s_ready, b1.m_valid, b1.m_last}, 32'd0);
        chk_eq("rst_core", {b1.core_init, b1.core_load, b1.core_fetch}, 32'd0);
        chk_eq("rst_data", {b1.m_data, b1.core_idata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_msg("post_rst", 32, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
